// File: rtl/trig_pkg.sv
// Shared types and constants for the trigger-detection stage.
// Channel config is packed as {en, edge, pol} per channel.
package trig_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    FIRE    = 2'd2,
    DONE    = 2'd3
  } trig_state_t;

  localparam int CFG_W    = 3;
  localparam int CFG_EN   = 2;
  localparam int CFG_EDGE = 1;
  localparam int CFG_POL  = 0;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a history flop for a single asynchronous bit.
// Provides the synchronized level plus rising/falling edge strobes.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;

  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~hist_q;
  assign fall = ~s2_q & hist_q;

endmodule

// File: rtl/trig_unit.sv
// Trigger qualification ahead of chan_capture: synchronizes channels and the
// external trigger, evaluates level/edge conditions and holds trig until done.
module trig_unit
  import trig_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int HOLD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         ch_in,
  input  logic                      ext_in,
  input  logic [CFG_W*NUM_CH-1:0]   ch_cfg,
  input  logic                      ext_en,
  input  logic [HOLD_W-1:0]         holdoff,
  input  logic                      armed,
  input  logic                      capture_done,
  output logic [NUM_CH-1:0]         ch_sync,
  output logic                      trig,
  output logic                      trig_fired
);

  logic [NUM_CH:0] raw_in;
  logic [NUM_CH:0] sync_v;
  logic [NUM_CH:0] rise_v;
  logic [NUM_CH:0] fall_v;

  // The external trigger rides on the top bit so it shares the synchronizer.
  assign raw_in = {ext_in, ch_in};

  for (genvar g = 0; g <= NUM_CH; g++) begin : g_sync
    sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (raw_in[g]),
      .sync (sync_v[g]),
      .rise (rise_v[g]),
      .fall (fall_v[g])
    );
  end

  assign ch_sync = sync_v[NUM_CH-1:0];

  trig_state_t               state_q, state_d;
  logic [HOLD_W-1:0]         cnt_q, cnt_d;
  logic [CFG_W*NUM_CH-1:0]   cfg_l_q, cfg_l_d;
  logic                      ext_en_l_q, ext_en_l_d;
  logic [HOLD_W-1:0]         holdoff_l_q, holdoff_l_d;
  logic                      trig_q, trig_d;
  logic                      trig_fired_q, trig_fired_d;

  logic any_en;
  logic any_edge;
  logic all_match;
  logic ch_match;
  logic cond;
  logic level_only;

  always_comb begin
    any_en    = 1'b0;
    any_edge  = 1'b0;
    all_match = 1'b1;
    ch_match  = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_l_q[CFG_W*i+CFG_EN]) begin
        any_en = 1'b1;
        if (cfg_l_q[CFG_W*i+CFG_EDGE]) begin
          any_edge = 1'b1;
          ch_match = cfg_l_q[CFG_W*i+CFG_POL] ? rise_v[i] : fall_v[i];
        end else begin
          ch_match = cfg_l_q[CFG_W*i+CFG_POL] ? sync_v[i] : ~sync_v[i];
        end
        all_match = all_match & ch_match;
      end
    end
    // With no channel enabled the AND term is suppressed so it cannot self-trigger.
    cond       = (any_en & all_match) | (ext_en_l_q & rise_v[NUM_CH]);
    level_only = ~any_edge & ~ext_en_l_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cfg_l_d     = cfg_l_q;
    ext_en_l_d  = ext_en_l_q;
    holdoff_l_d = holdoff_l_q;
    unique case (state_q)
      IDLE: begin
        if (armed && !capture_done) begin
          state_d     = QUALIFY;
          cnt_d       = '0;
          cfg_l_d     = ch_cfg;
          ext_en_l_d  = ext_en;
          holdoff_l_d = holdoff;
        end
      end
      QUALIFY: begin
        if (!armed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cond && (!level_only || (cnt_q == holdoff_l_q))) begin
          state_d = FIRE;
          cnt_d   = '0;
        end else if (cond && level_only) begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = '0;
        end
      end
      FIRE: begin
        if (capture_done) state_d = DONE;
      end
      DONE: begin
        // Waiting for capture_done to clear keeps a stale flag from retriggering.
        if (!capture_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    trig_d       = (state_d == FIRE);
    trig_fired_d = (state_d == FIRE) && (state_q != FIRE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cfg_l_q      <= '0;
      ext_en_l_q   <= 1'b0;
      holdoff_l_q  <= '0;
      trig_q       <= 1'b0;
      trig_fired_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_l_q      <= cfg_l_d;
      ext_en_l_q   <= ext_en_l_d;
      holdoff_l_q  <= holdoff_l_d;
      trig_q       <= trig_d;
      trig_fired_q <= trig_fired_d;
    end
  end

  assign trig       = trig_q;
  assign trig_fired = trig_fired_q;

endmodule

// File: doc/trig_unit.md
Name: trig_unit

Overview:
- Trigger-detection stage directly upstream of chan_capture.
- Synchronizes the raw analyzer channel inputs and an external trigger input.
- Evaluates per-channel level/edge conditions plus an optional level glitch filter, and drives the trig input of chan_capture.
- Only qualifies while chan_capture reports armed; holds trig until capture_done closes the capture.

Parameters:
NUM_CH, 5, number of analyzer channels.
HOLD_W, 8, width of the level-qualification (glitch filter) counter.

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  asynchronous active-high reset.
ch_in  input  NUM_CH  raw asynchronous channel inputs.
ext_in  input  1  raw asynchronous external trigger input.
ch_cfg  input  3*NUM_CH  per-channel config; bits [3i+2:3i] = {en, edge, pol}.
ext_en  input  1  enables the external trigger source.
holdoff  input  HOLD_W  extra consecutive cycles a level condition must persist.
armed  input  1  from chan_capture; pre-trigger buffer filled.
capture_done  input  1  capture-complete flag (register owned elsewhere).
ch_sync  output  NUM_CH  synchronized channel samples, to the sample data path.
trig  output  1  to chan_capture.
trig_fired  output  1  one-cycle pulse when trig rises.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous and active-high (rst).
- On rst, all flops clear: state=IDLE, trig=0, trig_fired=0, ch_sync=0, counter=0, latched config=0.
- Synchronizer: ch_in and ext_in each pass through 2 flops; the 2nd stage drives ch_sync.
  - A 3rd history flop per bit supports edge detection.
  - Input-to-ch_sync latency is 2 cycles.
- Per-channel match i (uses latched config):
  - en=0: match=1 (don't care).
  - edge=0, pol=1: match = sync.
  - edge=0, pol=0: match = ~sync.
  - edge=1, pol=1: match = sync & ~hist (rising edge).
  - edge=1, pol=0: match = ~sync & hist (falling edge).
- Condition cond = (any en & AND of all matches) | (ext_en_l & ext rising edge).
  - No channel enabled and ext_en_l=0: cond never asserts.
- Latched config: ch_cfg and ext_en are latched into *_l, and holdoff is latched, on the IDLE->QUALIFY transition only. Changes while not IDLE are ignored.
- FSM states and transitions:
  - IDLE: trig=0. Goes to QUALIFY when armed=1 and capture_done=0; config is latched on this transition.
  - QUALIFY: trig=0; counter runs.
    - armed=0 -> IDLE, counter cleared. This has priority over everything else.
    - Level-only config (no enabled channel has edge=1, and ext_en_l=0): counter increments while cond=1 and clears to 0 when cond=0. Go to FIRE on the cycle cond=1 with counter==holdoff_l. holdoff=0 fires on the first cycle cond=1; holdoff=N needs N+1 consecutive cycles.
    - Any edge term or ext enabled: holdoff is ignored; go to FIRE on the first cycle cond=1.
    - Counter saturates at all-ones and never wraps.
  - FIRE: trig=1 (registered; rises the cycle after qualification). trig_fired=1 for the first cycle in FIRE only.
    - Stays in FIRE regardless of armed or cond.
    - Goes to DONE when capture_done=1; trig deasserts on entering DONE.
  - DONE: trig=0. Goes to IDLE when capture_done=0, which prevents an immediate retrigger.
- Simultaneous events:
  - armed falling in the same cycle as qualification: IDLE wins, no trig.
  - capture_done=1 while in IDLE: stay in IDLE.
- Reset asserted mid-capture: trig drops asynchronously, FSM returns to IDLE.

Decomposition:
- Package trig_pkg:
  - State enum: IDLE, QUALIFY, FIRE, DONE.
  - Config field offsets: CFG_EN=2, CFG_EDGE=1, CFG_POL=0.
  - Localparam CFG_W=3.
- Sub-module sync_edge, instantiated NUM_CH+1 times: 2-flop synchronizer plus history flop; outputs sync, rise, fall.

Test Plan:
1. Reset; ch_cfg ch0={1,0,1}, holdoff=0, armed=1; ch_in[0]=1 -> ch_sync[0] rises after 2 clks; trig=1 one clk after qualification; trig_fired pulses for exactly 1 clk.
2. Level ch0 high, holdoff=3; 2-cycle glitch then a 4-cycle pulse -> no trig on the glitch; trig on the 4th consecutive high cycle.
3. ch1={1,1,0} falling edge AND ch2={1,0,1} level high; ch1 falls while ch2=0, then again while ch2=1 -> trig only on the second fall, holdoff=200 ignored.
4. ext_en=1, all channels disabled; ext_in 0->1 while armed=0 -> no trig; repeat with armed=1 -> trig; change ch_cfg while in FIRE -> no effect.
5. In FIRE, capture_done=1 for 3 clks, then 0 -> trig=0 in DONE, back to IDLE; condition still true but armed=0 -> no retrigger.
6. rst pulsed while in FIRE -> trig=0 immediately; after release state is IDLE and ch_sync=0.
